// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit.
package fetch_pkg;

  // One fetch packet is a naturally aligned 16-byte line of four instructions.
  localparam int PKT_W  = 128;
  localparam int INSN_W = 32;
  localparam int SLOTS  = PKT_W / INSN_W;

  // ADDI x0, x0, 0 -- the canonical RISC-V NOP.
  localparam logic [INSN_W-1:0] DEFAULT_NOP_INSN = 32'h0000_0013;

  typedef logic [PKT_W-1:0] pkt_t;

  // IDLE  : one-cycle settle after reset
  // REQ   : presenting a line request to instruction memory
  // WAIT  : request accepted, waiting for its response
  // HOLD  : packet captured, waiting for room in the FIFO
  // DRAIN : a redirect made the in-flight response stale; swallow it
  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_e;

endpackage

// File: rtl/fetch_slot_mask.sv
// fetch_slot_mask: replaces the instruction slots that lie before the fetch
// PC within a line by NOP_INSN, so a jump into the middle of a line does not
// execute the instructions that precede the target.
module fetch_slot_mask
  import fetch_pkg::*;
#(
  parameter logic [INSN_W-1:0] NOP_INSN = DEFAULT_NOP_INSN
) (
  input  logic [PKT_W-1:0] data,
  input  logic [1:0]       offset,
  output logic [PKT_W-1:0] masked
);

  // Slot i keeps its word when i >= offset, otherwise it becomes a NOP.
  always_comb begin
    masked = data;
    for (int i = 0; i < SLOTS; i++) begin
      if (i < int'(offset)) begin
        masked[i*INSN_W +: INSN_W] = NOP_INSN;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetches one 16-byte line (four instructions) at a time from
// instruction memory and pushes it into the downstream instruction FIFO.
// At most one memory request is in flight. A redirect wins over everything
// else: it reloads the PC and throws away any packet or response that belongs
// to the old instruction stream.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = DEFAULT_NOP_INSN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [31:0]      redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [31:0]      imem_req_addr,
  input  logic             imem_resp_valid,
  input  logic [PKT_W-1:0] imem_resp_data,
  output logic             fifo_write,
  output logic [PKT_W-1:0] fifo_data,
  input  logic             fifo_full
);

  fetch_state_e state;
  fetch_state_e state_next;

  // Instructions are word aligned, so only the word address is stored.
  logic [31:2] pc;
  pkt_t        pkt_q;
  pkt_t        resp_masked;
  logic        capture;

  // The byte offset of a redirect target carries no information for
  // 32-bit instructions and is dropped.
  logic unused_redirect_bits;
  assign unused_redirect_bits = ^redirect_pc[1:0];

  fetch_slot_mask #(
    .NOP_INSN (NOP_INSN)
  ) u_slot_mask (
    .data   (imem_resp_data),
    .offset (pc[3:2]),
    .masked (resp_masked)
  );

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // register in the design samples the values from before the clock edge.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; redirect is checked first in every state.
  always_comb begin
    // NOTE: state_next gets a default before the case so every path assigns
    // it; a path that leaves it unassigned would infer a latch.
    state_next = state;
    case (state)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        if (redirect_valid) begin
          state_next = REQ;
        end else if (imem_req_ready) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          // A response arriving together with the redirect is already stale
          // and is consumed here; otherwise it is still on its way.
          state_next = imem_resp_valid ? REQ : DRAIN;
        end else if (imem_resp_valid) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (redirect_valid || !fifo_full) begin
          state_next = REQ;
        end
      end
      DRAIN: begin
        // Further redirects only move the PC. Once the stale response has
        // been swallowed nothing is left in flight, so a redirect in that
        // same cycle cannot hold the FSM here.
        if (imem_resp_valid) begin
          state_next = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode; redirect suppresses both the request and the push.
  always_comb begin
    imem_req_valid = 1'b0;
    fifo_write     = 1'b0;
    case (state)
      REQ:     imem_req_valid = !redirect_valid;
      HOLD:    fifo_write     = !fifo_full && !redirect_valid;
      default: ;
    endcase
  end

  assign imem_req_addr = {pc[31:4], 4'h0};
  assign fifo_data     = pkt_q;

  // Only a response that belongs to the current stream is kept.
  assign capture = (state == WAIT) && imem_resp_valid && !redirect_valid;

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------

  // PC: redirect target, else the next line once the packet is pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC[31:2];
    end else if (redirect_valid) begin
      pc <= redirect_pc[31:2];
    end else if (fifo_write) begin
      // Line address wraps modulo 2^32.
      pc <= {pc[31:4] + 28'd1, 2'b00};
    end
  end

  // Packet register: captures the masked response, holds it under back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this wide data register is reset because fifo_data must read as
    // zero while reset is asserted; pure datapath storage normally is not.
    if (!rst_n) begin
      pkt_q <= '0;
    end else if (capture) begin
      pkt_q <= resp_masked;
    end
  end

  // ---------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------

  // An accepted request is always followed by waiting for its response, so
  // a second request can never be issued while one is outstanding.
  a_req_then_wait : assert property (@(posedge clk) disable iff (!rst_n)
    (imem_req_valid && imem_req_ready) |=> (state == WAIT));

  // The FIFO is never written while it reports full.
  a_push_not_full : assert property (@(posedge clk) disable iff (!rst_n)
    fifo_write |-> !fifo_full);

  // A push always returns the FSM to requesting the next line.
  a_push_then_req : assert property (@(posedge clk) disable iff (!rst_n)
    fifo_write |=> (state == REQ));

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC loaded at reset.
REQ-002 Parameter NOP_INSN, default 32'h0000_0013, SHALL set the instruction word substituted into masked slots.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 redirect_valid  input  1  branch/exception redirect request.
REQ-006 redirect_pc  input  32  redirect target; bits [1:0] SHALL be ignored.
REQ-007 imem_req_valid  output  1  instruction-memory request valid.
REQ-008 imem_req_ready  input  1  instruction memory accepts the request.
REQ-009 imem_req_addr  output  32  16-byte-aligned fetch address, {pc[31:4],4'b0}.
REQ-010 imem_resp_valid  input  1  response data valid, one cycle per accepted request.
REQ-011 imem_resp_data  input  128  four instructions; slot i = bits [32i+31:32i], slot 0 at the lowest address.
REQ-012 fifo_write  output  1  push to the downstream instruction FIFO.
REQ-013 fifo_data  output  128  packet pushed to the FIFO.
REQ-014 fifo_full  input  1  downstream FIFO full.

Function
REQ-015 The state machine SHALL have the states IDLE, REQ, WAIT, HOLD and DRAIN.
REQ-016 IDLE SHALL go to REQ unconditionally on the next cycle.
REQ-017 imem_req_valid SHALL equal (state==REQ && !redirect_valid).
REQ-018 REQ SHALL go to WAIT when imem_req_valid && imem_req_ready.
REQ-019 At most one request SHALL be outstanding.
REQ-020 In WAIT, on imem_resp_valid, the block SHALL register the packet into pkt_q with slots below pc[3:2] replaced by NOP_INSN, and SHALL go to HOLD.
REQ-021 fifo_write SHALL equal (state==HOLD && !fifo_full && !redirect_valid), and fifo_data SHALL equal pkt_q.
REQ-022 On a fifo_write cycle, pc SHALL become {pc[31:4]+28'd1, 4'b0} and the state SHALL become REQ; the address SHALL wrap modulo 2^32.
REQ-023 HOLD with fifo_full SHALL remain in HOLD with pkt_q unchanged (back-pressure, no loss).
REQ-024 redirect_valid SHALL have priority in every state: pc <= {redirect_pc[31:2],2'b00}.
REQ-025 On redirect in REQ or HOLD, the next state SHALL be REQ; any pending packet SHALL be dropped and not written.
REQ-026 On redirect in WAIT without imem_resp_valid, the next state SHALL be DRAIN.
REQ-027 On redirect in WAIT with imem_resp_valid in the same cycle, the response SHALL be discarded and the next state SHALL be REQ.
REQ-028 DRAIN SHALL discard the next imem_resp_valid response and then go to REQ.
REQ-029 A further redirect in DRAIN SHALL update pc and the state SHALL stay in DRAIN.
REQ-030 A redirect in IDLE SHALL update pc, and the state SHALL go to REQ.
REQ-031 imem_resp_valid SHALL be ignored in IDLE, REQ and HOLD.
REQ-032 Throughput SHALL be at most one packet per three cycles; request-to-push latency SHALL be the response delay plus one cycle.

Reset
REQ-033 While rst_n is low: state=IDLE, pc=RESET_PC, pkt_q=128'd0.
REQ-034 While rst_n is low: imem_req_valid=0, fifo_write=0, fifo_data=0, imem_req_addr={RESET_PC[31:4],4'b0}.
REQ-035 Reset assertion mid-transaction SHALL abandon any outstanding request immediately; any stale response after release SHALL be ignored because the state is IDLE/REQ.

Structure
REQ-036 A shared package fetch_pkg SHALL hold the state enum, the default NOP_INSN and the packet width constant (128).
REQ-037 Slot masking SHALL be a combinational sub-module fetch_slot_mask (inputs: 128-bit data, 2-bit offset; output: masked 128-bit data).
REQ-038 The PC register, FSM and pkt_q SHALL reside in fetch_unit.

Verification
REQ-039 Release reset with RESET_PC=0 and ready=1 and a 1-cycle response delay -> addresses 0x0, 0x10, 0x20 are issued and each packet is pushed once, in order.
REQ-040 Redirect to 0x108 -> next address 0x100; slots 0-1 = 0x00000013; slots 2-3 = the memory words at 0x108/0x10C.
REQ-041 Hold fifo_full=1 for 10 cycles while in HOLD -> fifo_write=0 and no new request; after release, exactly one push of the unchanged packet.
REQ-042 Redirect in WAIT with the response 3 cycles later -> the response is discarded (no push); the next request goes to the redirect address.
REQ-043 Redirect coincident with imem_resp_valid, and separately coincident with a HOLD cycle where fifo_full=0 -> no push in either case; the next request goes to the redirect address.
REQ-044 pc=0xFFFF_FFF0 pushed -> next address 0x0000_0000.
